// File: rtl/dps_mtim.sv
// Multi-channel prescaled match timer with a small register interface.
// Channels share one prescaler tick; each channel counts up to its compare
// value, flags the match and optionally stops (one-shot). Matches on
// interrupt-enabled channels raise a level interrupt held until acknowledged.
module dps_mtim #(
   parameter int P_CH    = 4,
   parameter int P_CNT_W = 32,
   parameter int P_PSC_W = 16
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iREQ_VALID,
   output logic        oREQ_BUSY,
   input  logic        iREQ_RW,
   input  logic [5:0]  iREQ_ADDR,
   input  logic [31:0] iREQ_DATA,
   output logic        oREQ_VALID,
   output logic [31:0] oREQ_DATA,
   output logic        oIRQ_VALID,
   input  logic        iIRQ_ACK
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} irq_st_t;

   localparam logic [5:0] ADDR_FLAGS = 6'h20;
   localparam logic [5:0] ADDR_PSC   = 6'h21;

   logic [2:0]         ctrl_q [P_CH];
   logic [2:0]         ctrl_d [P_CH];
   logic [P_CNT_W-1:0] cnt_q  [P_CH];
   logic [P_CNT_W-1:0] cnt_d  [P_CH];
   logic [P_CNT_W-1:0] cmp_q  [P_CH];
   logic [P_CNT_W-1:0] cmp_d  [P_CH];
   logic [P_CH-1:0]    flags_q, flags_d;
   logic [P_PSC_W-1:0] psc_q, psc_d;
   logic [P_PSC_W-1:0] psc_cnt_q, psc_cnt_d;
   logic               rd_pend_q, rd_pend_d;
   logic [31:0]        rdata_q, rdata_d;
   irq_st_t            irq_st_q, irq_st_d;

   logic               acc_rd_s, acc_wr_s, wr_ch_s, tick_s, evt_s;
   logic [2:0]         ch_idx_s;
   logic [1:0]         reg_k_s;
   logic [31:0]        rd_s;
   logic [P_CH-1:0]    match_s, ien_s, clr_s;

   // Request acceptance, address split and prescaler tick.
   always_comb begin
      acc_rd_s = iREQ_VALID & ~rd_pend_q & iREQ_RW;
      acc_wr_s = iREQ_VALID & ~rd_pend_q & ~iREQ_RW;
      ch_idx_s = iREQ_ADDR[4:2];
      reg_k_s  = iREQ_ADDR[1:0];
      wr_ch_s  = acc_wr_s & ~iREQ_ADDR[5];
      tick_s   = (psc_cnt_q == psc_q);
   end

   // Read data mux; unmapped and absent channels read as zero.
   always_comb begin
      rd_s = 32'd0;
      if (iREQ_ADDR == ADDR_FLAGS) begin
         rd_s[P_CH-1:0] = flags_q;
      end else if (iREQ_ADDR == ADDR_PSC) begin
         rd_s[P_PSC_W-1:0] = psc_q;
      end else if (!iREQ_ADDR[5]) begin
         for (int n = 0; n < P_CH; n++) begin
            if (ch_idx_s == 3'(n)) begin
               case (reg_k_s)
                  2'd0:    rd_s[2:0]         = ctrl_q[n];
                  2'd1:    rd_s[P_CNT_W-1:0] = cnt_q[n];
                  2'd2:    rd_s[P_CNT_W-1:0] = cmp_q[n];
                  default: rd_s              = 32'd0;
               endcase
            end
         end
      end else begin
         rd_s = 32'd0;
      end
   end

   // Channel next state: a register write wins over the tick action.
   always_comb begin
      for (int n = 0; n < P_CH; n++) begin
         ctrl_d[n]  = ctrl_q[n];
         cnt_d[n]   = cnt_q[n];
         cmp_d[n]   = cmp_q[n];
         match_s[n] = 1'b0;
         ien_s[n]   = ctrl_q[n][2];
         if (wr_ch_s && (ch_idx_s == 3'(n))) begin
            case (reg_k_s)
               2'd0:    ctrl_d[n] = iREQ_DATA[2:0];
               2'd1:    cnt_d[n]  = iREQ_DATA[P_CNT_W-1:0];
               2'd2:    cmp_d[n]  = iREQ_DATA[P_CNT_W-1:0];
               default: ctrl_d[n] = ctrl_q[n];
            endcase
         end else if (tick_s && ctrl_q[n][0]) begin
            if (cnt_q[n] == cmp_q[n]) begin
               match_s[n]   = 1'b1;
               cnt_d[n]     = '0;
               ctrl_d[n][0] = ctrl_q[n][1];
            end else begin
               cnt_d[n] = cnt_q[n] + P_CNT_W'(1);
            end
         end else begin
            cnt_d[n] = cnt_q[n];
         end
      end
   end

   // Flags, prescaler and read-response next state.
   always_comb begin
      clr_s     = (acc_rd_s && (iREQ_ADDR == ADDR_FLAGS)) ? flags_q : '0;
      flags_d   = (flags_q & ~clr_s) | match_s;
      evt_s     = |(match_s & ~flags_q & ien_s);
      psc_d     = psc_q;
      if (acc_wr_s && (iREQ_ADDR == ADDR_PSC)) begin
         psc_d     = iREQ_DATA[P_PSC_W-1:0];
         psc_cnt_d = '0;
      end else if (tick_s) begin
         psc_cnt_d = '0;
      end else begin
         psc_cnt_d = psc_cnt_q + P_PSC_W'(1);
      end
      rd_pend_d = acc_rd_s;
      rdata_d   = acc_rd_s ? rd_s : 32'd0;
   end

   // Interrupt state machine next state.
   always_comb begin
      irq_st_d = irq_st_q;
      case (irq_st_q)
         ST_IDLE: irq_st_d = evt_s ? ST_PEND : ST_IDLE;
         ST_PEND: irq_st_d = (iIRQ_ACK && !evt_s) ? ST_IDLE : ST_PEND;
         default: irq_st_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         for (int n = 0; n < P_CH; n++) begin
            ctrl_q[n] <= '0;
            cnt_q[n]  <= '0;
            cmp_q[n]  <= '0;
         end
         flags_q   <= '0;
         psc_q     <= '0;
         psc_cnt_q <= '0;
         rd_pend_q <= 1'b0;
         rdata_q   <= 32'd0;
         irq_st_q  <= ST_IDLE;
      end else begin
         for (int n = 0; n < P_CH; n++) begin
            ctrl_q[n] <= ctrl_d[n];
            cnt_q[n]  <= cnt_d[n];
            cmp_q[n]  <= cmp_d[n];
         end
         flags_q   <= flags_d;
         psc_q     <= psc_d;
         psc_cnt_q <= psc_cnt_d;
         rd_pend_q <= rd_pend_d;
         rdata_q   <= rdata_d;
         irq_st_q  <= irq_st_d;
      end
   end

   // A reset in the response cycle suppresses the pending read response.
   assign oREQ_BUSY  = rd_pend_q & ~iRESET_SYNC;
   assign oREQ_VALID = rd_pend_q & ~iRESET_SYNC;
   assign oREQ_DATA  = iRESET_SYNC ? 32'd0 : rdata_q;
   assign oIRQ_VALID = (irq_st_q == ST_PEND);

endmodule

// File: doc/dps_mtim.md
DPS_MTIM -- requirements
Module: dps_mtim

Interface
REQ-001 Parameter P_CH, default 4, number of timer channels (legal 1..8).
REQ-002 Parameter P_CNT_W, default 32, counter/compare width in bits (legal 8..32).
REQ-003 Parameter P_PSC_W, default 16, prescaler width in bits (legal 1..32).
REQ-004 iCLOCK  in  1  sole clock; all state on rising edge.
REQ-005 iRESET_SYNC  in  1  synchronous, active-high reset.
REQ-006 iREQ_VALID  in  1  register request strobe.
REQ-007 oREQ_BUSY  out  1  request not accepted this cycle.
REQ-008 iREQ_RW  in  1  1 = read, 0 = write.
REQ-009 iREQ_ADDR  in  6  word address.
REQ-010 iREQ_DATA  in  32  write data.
REQ-011 oREQ_VALID  out  1  read data valid, one-cycle pulse.
REQ-012 oREQ_DATA  out  32  read data.
REQ-013 oIRQ_VALID  out  1  interrupt pending level.
REQ-014 iIRQ_ACK  in  1  interrupt acknowledge.

Function
REQ-015 Register map, channel n at 4n+k:
- k=0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IEN.
- k=1 COUNT.
- k=2 COMPARE.
- k=3 reads 0.
- 0x20 FLAGS: bit n = channel n match flag; read-to-clear.
- 0x21 PSC: prescaler reload.
- Unmapped or n>=P_CH addresses: read 0, writes ignored.
REQ-016 Request accepted when iREQ_VALID=1 and oREQ_BUSY=0; otherwise ignored, no side effect.
REQ-017 Accepted write updates the register at the next edge; no response pulse.
REQ-018 Accepted read gives oREQ_VALID=1 with data exactly one cycle later.
- oREQ_BUSY=1 during that response cycle; oREQ_BUSY=0 otherwise.
- Back-to-back reads therefore have 2-cycle throughput.
REQ-019 oREQ_DATA=0 whenever oREQ_VALID=0.
- Fields narrower than 32 bits are zero-extended; writes truncate to field width.
REQ-020 Prescaler: internal counter psc_cnt increments every cycle.
- When psc_cnt==PSC: psc_cnt<=0 and a one-cycle tick is generated.
- PSC=0 gives a tick every cycle.
- Writing PSC also clears psc_cnt.
REQ-021 On tick, each channel with EN=1:
- If COUNT==COMPARE: set flag n and COUNT<=0; if PERIODIC=0, EN<=0 (one-shot).
- Else COUNT<=COUNT+1, wrapping 2^P_CNT_W-1 -> 0 with no flag.
- Channels with EN=0 hold COUNT.
REQ-022 A write to any register of channel n in a cycle suppresses that channel's tick action; the write value wins.
REQ-023 FLAGS read returns the flags as held before the clearing edge and clears exactly the bits returned.
- A match event in the same cycle as the clear leaves that bit set.
REQ-024 Interrupt state machine, states IDLE and PEND; oIRQ_VALID=1 iff PEND.
- An event is any flag n newly set with IEN(n)=1.
- IDLE -> PEND on event.
- PEND -> IDLE on iIRQ_ACK=1 with no event that cycle.
- ACK coincident with an event stays PEND.
REQ-025 IEN=0 channels still set FLAGS bits but never raise an interrupt.
- Setting IEN later does not retro-raise for flags already set.

Reset
REQ-026 While iRESET_SYNC=1 at an edge, all of the following are cleared to 0: CTRL, COUNT, COMPARE, FLAGS, PSC, psc_cnt, pending read, IRQ state (IDLE).
- Outputs are 0 during the cycle after reset, including oREQ_BUSY, oREQ_VALID, oREQ_DATA and oIRQ_VALID.
REQ-027 Reset asserted during a pending read cancels the response; no oREQ_VALID follows.

Verification
REQ-028 PSC=0, ch0 COMPARE=3, CTRL=0x7 -> FLAGS bit0 set and oIRQ_VALID=1 four ticks after enable; COUNT=0; ch0 continues counting.
REQ-029 ch1 CTRL=0x5 (one-shot), COMPARE=2, PSC=1 -> match after 6 cycles; CTRL reads 0x4; COUNT stays 0.
REQ-030 COUNT=0xFFFFFFFF, COMPARE=5, EN=1 -> next tick COUNT=0 with no flag; flag set on the 6th subsequent tick.
REQ-031 FLAGS read coincident with ch2 match while bit0 set -> read returns 0x01; FLAGS afterwards 0x04; oIRQ_VALID stays 1 through an iIRQ_ACK in that cycle.
REQ-032 Two requests on consecutive cycles -> second ignored (oREQ_BUSY=1); read of address 0x3F returns 0; with P_CH=2, read of 0x08 returns 0.
REQ-033 iRESET_SYNC pulsed in the cycle after a read is accepted -> no oREQ_VALID; all registers read 0; oIRQ_VALID=0.
